// File: rtl/seq_cmp.sv
// Multi-cycle magnitude comparator: scans WIDTH-bit operands CHUNK bits per clock, MSB chunk first,
// stopping at the first unequal chunk. Define SEQ_CMP_SIGNED_EN to add two's-complement compare via signed_mode.
module seq_cmp #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SEQ_CMP_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);
    localparam logic [CHUNK-1:0] TOP_BIT = CHUNK'(1) << (CHUNK - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state, state_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic [WIDTH-1:0] ar, ar_d, br, br_d;
    logic             gt_d, eq_d, lt_d;
    logic [CHUNK-1:0] flip_c, ca_c, cb_c;

`ifdef SEQ_CMP_SIGNED_EN
    logic sm, sm_d;
    // Inverting the sign bit of the top chunk turns a two's-complement compare into an unsigned one.
    assign flip_c = (sm && (idx == IDX_TOP)) ? TOP_BIT : '0;
`else
    assign flip_c = '0;
`endif

    assign ca_c = ar[idx*CHUNK +: CHUNK] ^ flip_c;
    assign cb_c = br[idx*CHUNK +: CHUNK] ^ flip_c;

    // Next-state and datapath update
    always_comb begin
        logic accept;
        state_d = state;
        idx_d   = idx;
        ar_d    = ar;
        br_d    = br;
        gt_d    = gt;
        eq_d    = eq;
        lt_d    = lt;
        accept  = 1'b0;
`ifdef SEQ_CMP_SIGNED_EN
        sm_d    = sm;
`endif
        case (state)
            IDLE: accept = start;
            SCAN: begin
                if (ca_c != cb_c) begin
                    gt_d    = (ca_c > cb_c);
                    lt_d    = (ca_c < cb_c);
                    eq_d    = 1'b0;
                    state_d = DONE;
                end else if (idx == '0) begin
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx - IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                accept  = start;
            end
            default: state_d = IDLE;
        endcase
        // The edge leaving DONE may accept a new request so comparisons run back to back.
        if (accept) begin
            ar_d    = A;
            br_d    = B;
            idx_d   = IDX_TOP;
            state_d = SCAN;
`ifdef SEQ_CMP_SIGNED_EN
            sm_d    = signed_mode;
`endif
        end
    end

    // State, operand and registered output update
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            ar    <= '0;
            br    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
`ifdef SEQ_CMP_SIGNED_EN
            sm    <= 1'b0;
`endif
        end else begin
            state <= state_d;
            idx   <= idx_d;
            ar    <= ar_d;
            br    <= br_d;
            busy  <= (state_d != IDLE);
            done  <= (state_d == DONE);
            gt    <= gt_d;
            eq    <= eq_d;
            lt    <= lt_d;
`ifdef SEQ_CMP_SIGNED_EN
            sm    <= sm_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_cmp.sv
// Directed self-checking bench for seq_cmp (WIDTH=16, CHUNK=2).
module tb_seq_cmp;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] a, b;
    logic        signed_mode;
    logic        busy, done, gt, eq, lt;

    int errs   = 0;
    int checks = 0;

    seq_cmp #(.WIDTH(16), .CHUNK(2)) dut (
        .clk(clk), .rst(rst), .start(start), .A(a), .B(b),
`ifdef SEQ_CMP_SIGNED_EN
        .signed_mode(signed_mode),
`endif
        .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rising edge, then land on the falling edge where outputs are sampled.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Start one comparison and check latency k, busy length, result and hold of the old result.
    task automatic run_cmp(input string tag, input logic [15:0] va, input logic [15:0] vb,
                           input logic sm, input int k, input logic [2:0] exp_res);
        logic [2:0] prev;
        int         n, busy_n;
        bit         held;
        prev        = {gt, eq, lt};
        a           = va;
        b           = vb;
        signed_mode = sm;
        start       = 1'b1;
        tick();
        start  = 1'b0;
        n      = 0;
        busy_n = 0;
        held   = 1'b1;
        while (!done && n < 40) begin
            if (busy) busy_n++;
            if ({gt, eq, lt} !== prev) held = 1'b0;
            tick();
            n++;
        end
        if (busy) busy_n++;
        check({tag, "_latency"}, 32'(n), 32'(k));
        check({tag, "_result"}, 32'({gt, eq, lt}), 32'(exp_res));
        check({tag, "_hold"}, 32'(held), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(k + 1));
        tick();
        check({tag, "_idle"}, 32'({busy, done}), 32'd0);
    endtask

    initial begin
        int first, ndone;
        rst         = 1'b1;
        start       = 1'b0;
        a           = '0;
        b           = '0;
        signed_mode = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_outputs", 32'({busy, done, gt, eq, lt}), 32'd0);

        run_cmp("eq_1234", 16'h1234, 16'h1234, 1'b0, 8, 3'b010);
        run_cmp("gt_8000", 16'h8000, 16'h7FFF, 1'b0, 1, 3'b100);
`ifdef SEQ_CMP_SIGNED_EN
        run_cmp("slt_8000", 16'h8000, 16'h7FFF, 1'b1, 1, 3'b001);
`endif
        run_cmp("lt_0001", 16'h0001, 16'h0002, 1'b0, 8, 3'b001);
        run_cmp("lt_0400", 16'h0400, 16'h0800, 1'b0, 3, 3'b001);

        // Starts during SCAN and operand changes after accept must be ignored.
        a     = 16'h00FF;
        b     = 16'h00F0;
        start = 1'b1;
        tick();
        first = -1;
        ndone = 0;
        for (int n = 1; n <= 20; n++) begin
            start = (n == 3 || n == 5);
            a     = '0;
            b     = 16'hFFFF;
            tick();
            if (done) begin
                ndone++;
                if (first < 0) first = n;
            end
        end
        start = 1'b0;
        check("ign_first_done", 32'(first), 32'd7);
        check("ign_done_count", 32'(ndone), 32'd1);
        check("ign_result", 32'({gt, eq, lt}), 32'b100);

        // Back-to-back: second start accepted on the edge that leaves DONE.
        a     = 16'h0003;
        b     = 16'h0003;
        start = 1'b1;
        tick();
        start = 1'b0;
        first = 0;
        while (!done && first < 40) begin
            tick();
            first++;
        end
        check("b2b_first_latency", 32'(first), 32'd8);
        check("b2b_first_result", 32'({gt, eq, lt}), 32'b010);
        a     = 16'hF000;
        b     = 16'h1000;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_gap", 32'({busy, done}), 32'b10);
        tick();
        check("b2b_second_done", 32'(done), 32'd1);
        check("b2b_second_result", 32'({gt, eq, lt}), 32'b100);
        tick();
        check("b2b_idle", 32'({busy, done}), 32'd0);

        // Reset mid-SCAN aborts without a done pulse.
        a     = 16'h1234;
        b     = 16'h1235;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_scan_outputs", 32'({busy, done, gt, eq, lt}), 32'd0);
        ndone = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (done) ndone++;
        end
        check("rst_scan_no_done", 32'(ndone), 32'd0);
        run_cmp("post_rst_lt", 16'h1234, 16'h1235, 1'b0, 8, 3'b001);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
